// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit buffering slice.
package uart_pkg;

  localparam int unsigned UART_DATA_W    = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 16;
  localparam int unsigned FIFO_AW_DEF    = 4;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

  // Handoff sequencer states toward the UART transmitter.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x byte storage: synchronous write, asynchronous read, no reset on contents.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned AW    = FIFO_AW_DEF
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  uart_byte_t    wr_data,
  input  logic [AW-1:0] rd_addr,
  output uart_byte_t    rd_data_c
);

  uart_byte_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data_c = mem_q[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO that paces queued bytes into the UART transmitter one at a time,
// issuing a single-cycle load strobe only while the transmitter is idle.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned AW    = FIFO_AW_DEF
) (
  input  logic                   clk_50m,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   flush,
  output logic [UART_DATA_W-1:0] din,
  output logic                   wr_en,
  input  logic                   tx_busy,
  output logic [AW:0]            count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow
);

  localparam int unsigned CW = AW + 1;

  tx_state_e     state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  uart_byte_t    din_q, din_d;
  logic          wr_en_q, wr_en_d;
  logic          overflow_q, overflow_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          s_ready_q, s_ready_d;

  logic          push_c;
  logic          pop_c;
  uart_byte_t    mem_rd_c;

  // Acceptance looks only at the registered fill state, so a full FIFO
  // rejects a byte even on an edge that also pops.
  assign push_c = s_valid && s_ready_q && !flush;
  assign pop_c  = (state_q == IDLE) && !empty_q && !tx_busy && !flush;

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk       (clk_50m),
    .wr_en     (push_c),
    .wr_addr   (wr_ptr_q),
    .wr_data   (s_data),
    .rd_addr   (rd_ptr_q),
    .rd_data_c (mem_rd_c)
  );

  // Pointer, occupancy and overflow bookkeeping; flush wins over push/pop.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    din_d      = din_q;

    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        din_d    = mem_rd_c;
      end
      if (push_c && !pop_c) begin
        count_d = count_q + CW'(1);
      end else if (pop_c && !push_c) begin
        count_d = count_q - CW'(1);
      end
      if (s_valid && full_q) begin
        overflow_d = 1'b1;
      end
    end

    empty_d   = (count_d == '0);
    full_d    = (count_d == CW'(DEPTH));
    s_ready_d = !full_d;
  end

  // Handoff sequencer: strobe, guard cycle for tx_busy to rise, then wait idle.
  always_comb begin
    state_d = state_q;
    wr_en_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pop_c) begin
          state_d = ISSUE;
          wr_en_d = 1'b1;
        end
      end
      ISSUE: state_d = HOLD;
      HOLD:  state_d = DRAIN;
      DRAIN: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      din_q      <= '0;
      wr_en_q    <= 1'b0;
      overflow_q <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      s_ready_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      din_q      <= din_d;
      wr_en_q    <= wr_en_d;
      overflow_q <= overflow_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      s_ready_q  <= s_ready_d;
    end
  end

  assign s_ready  = s_ready_q;
  assign din      = din_q;
  assign wr_en    = wr_en_q;
  assign count    = count_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized and directed bench for uart_tx_fifo against a queue-based
// reference model and a simple transmitter busy model.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  typedef logic [7:0] u8_t;

  logic        clk_50m = 1'b0;
  logic        rst;
  u8_t         s_data;
  logic        s_valid;
  logic        s_ready;
  logic        flush;
  u8_t         din;
  logic        wr_en;
  logic        tx_busy;
  logic [AW:0] count;
  logic        empty;
  logic        full;
  logic        overflow;

  uart_tx_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk_50m  (clk_50m),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .flush    (flush),
    .din      (din),
    .wr_en    (wr_en),
    .tx_busy  (tx_busy),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
  );

  always #10 clk_50m = ~clk_50m;

  int n_tot = 0;
  int n_bad = 0;

  // Reference model: queued bytes plus the number of handoff cycles still owed
  // (3 = strobe cycle, 2 = guard cycle, 1 = waiting for the transmitter to go idle).
  u8_t m_q[$];
  bit  m_ovf;
  int  m_owed;
  bit  m_wr_en;
  u8_t m_din;
  bit  m_pushed;

  // Transmitter model and observed output stream.
  int  busy_len = 0;
  int  busy_cnt = 0;
  bit  stuck    = 1'b0;
  u8_t seen[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf    = 1'b0;
    m_owed   = 0;
    m_wr_en  = 1'b0;
    m_din    = 8'h00;
    m_pushed = 1'b0;
  endtask

  task automatic model_edge();
    bit is_full;
    bit pop;
    bit push;
    if (rst) begin
      model_reset();
    end else begin
      is_full  = (m_q.size() == DEPTH);
      pop      = (m_owed == 0) && (m_q.size() != 0) && !tx_busy && !flush;
      push     = s_valid && !is_full && !flush;
      m_pushed = push;
      m_wr_en  = pop;
      if (pop) m_din = m_q.pop_front();
      if (pop) m_owed = 3;
      else if (m_owed == 3) m_owed = 2;
      else if (m_owed == 2) m_owed = 1;
      else if (m_owed == 1 && !tx_busy) m_owed = 0;
      if (flush) begin
        m_q.delete();
        m_ovf = 1'b0;
      end else begin
        if (s_valid && is_full) m_ovf = 1'b1;
        if (push) m_q.push_back(s_data);
      end
    end
  endtask

  task automatic update_busy();
    tx_busy = stuck || (busy_cnt > 0);
  endtask

  task automatic step();
    @(posedge clk_50m);
    model_edge();
    @(negedge clk_50m);
    chk("wr_en",    32'(wr_en),    32'(m_wr_en));
    chk("din",      32'(din),      32'(m_din));
    chk("count",    32'(count),    32'(m_q.size()));
    chk("empty",    32'(empty),    32'(m_q.size() == 0));
    chk("full",     32'(full),     32'(m_q.size() == DEPTH));
    chk("s_ready",  32'(s_ready),  32'(m_q.size() != DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (wr_en === 1'b1) begin
      seen.push_back(din);
      busy_cnt = busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    update_busy();
  endtask

  task automatic push_byte(input u8_t b);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data  = b;
    for (int i = 0; i < 400; i++) begin
      step();
      if (m_pushed) begin
        ok = 1'b1;
        break;
      end
    end
    s_valid = 1'b0;
    chk("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic drain_wait(input int max_cycles);
    bit done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (m_q.size() == 0 && m_owed == 0 && !tx_busy) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk("drain_done", 32'(done), 32'd1);
  endtask

  task automatic check_seq(input string tag, input u8_t exp[$]);
    chk(tag, 32'(seen.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < seen.size(); i++) begin
      chk(tag, 32'(seen[i]), 32'(exp[i]));
    end
  endtask

  // Asynchronous reset from the current negedge; outputs must clear without a clock.
  task automatic reset_now();
    rst      = 1'b1;
    s_valid  = 1'b0;
    flush    = 1'b0;
    stuck    = 1'b0;
    busy_cnt = 0;
    update_busy();
    #1;
    chk("rst_wr_en",    32'(wr_en),    32'd0);
    chk("rst_din",      32'(din),      32'h00);
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_s_ready",  32'(s_ready),  32'd1);
    chk("rst_overflow", 32'(overflow), 32'd0);
    model_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    u8_t exp[$];
    bit  did_rst = 1'b0;
    bit  aligned;

    rst     = 1'b1;
    s_data  = 8'h00;
    s_valid = 1'b0;
    flush   = 1'b0;
    tx_busy = 1'b0;
    model_reset();
    repeat (3) step();
    rst = 1'b0;
    step();

    // Ordered drain with a slow transmitter.
    seen.delete();
    busy_len = 100;
    push_byte(8'h41);
    push_byte(8'h42);
    push_byte(8'h43);
    drain_wait(1000);
    exp = '{8'h41, 8'h42, 8'h43};
    check_seq("drain_seq", exp);
    chk("drain_count", 32'(count), 32'd0);

    // Full boundary with the transmitter stuck busy; 17th byte overflows.
    seen.delete();
    stuck = 1'b1;
    update_busy();
    for (int i = 0; i < 17; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      step();
    end
    s_valid = 1'b0;
    chk("full_count",    32'(count),       32'd16);
    chk("full_flag",     32'(full),        32'd1);
    chk("full_s_ready",  32'(s_ready),     32'd0);
    chk("full_overflow", 32'(overflow),    32'd1);
    chk("full_no_wr_en", 32'(seen.size()), 32'd0);
    stuck    = 1'b0;
    busy_len = 3;
    update_busy();
    drain_wait(600);
    exp.delete();
    for (int i = 0; i < 16; i++) exp.push_back(8'(i));
    check_seq("full_seq", exp);
    chk("sticky_overflow", 32'(overflow), 32'd1);

    // Flush while the first byte is in its busy wait with five more queued.
    seen.delete();
    busy_len = 100;
    for (int i = 0; i < 6; i++) push_byte(8'(8'hB0 + i));
    chk("pre_flush_count", 32'(count), 32'd5);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_count",    32'(count),    32'd0);
    chk("flush_overflow", 32'(overflow), 32'd0);
    chk("flush_empty",    32'(empty),    32'd1);
    push_byte(8'hA5);
    drain_wait(400);
    exp = '{8'hB0, 8'hA5};
    check_seq("flush_seq", exp);

    // Push exactly on pop edges so occupancy holds at one across several wraps.
    seen.delete();
    busy_len = 0;
    stuck    = 1'b1;
    update_busy();
    push_byte(8'h60);
    stuck = 1'b0;
    update_busy();
    exp = '{8'h60};
    for (int i = 1; i <= 3 * DEPTH; i++) begin
      aligned = 1'b0;
      for (int w = 0; w < 20; w++) begin
        if (m_owed == 0 && m_q.size() == 1 && !tx_busy) begin
          aligned = 1'b1;
          break;
        end
        step();
      end
      chk("pp_align", 32'(aligned), 32'd1);
      s_valid = 1'b1;
      s_data  = 8'(8'h60 + i);
      exp.push_back(8'(8'h60 + i));
      step();
      s_valid = 1'b0;
      chk("pp_count", 32'(count), 32'd1);
    end
    drain_wait(200);
    check_seq("pp_seq", exp);

    // Forty-byte incrementing stream under a short busy time.
    seen.delete();
    busy_len = 2;
    exp.delete();
    for (int i = 0; i < 40; i++) begin
      push_byte(8'(8'hC0 + i));
      exp.push_back(8'(8'hC0 + i));
    end
    drain_wait(1000);
    check_seq("wrap_seq", exp);

    // Random traffic with rare flushes, stuck-busy spells and one mid-frame reset.
    for (int i = 0; i < 3000; i++) begin
      s_valid  = ($urandom_range(0, 3) == 0);
      s_data   = 8'($urandom);
      flush    = ($urandom_range(0, 63) == 0);
      busy_len = $urandom_range(0, 6);
      if ($urandom_range(0, 199) == 0) stuck = !stuck;
      update_busy();
      step();
      if (!did_rst && i > 1500 && wr_en === 1'b1) begin
        reset_now();
        did_rst = 1'b1;
      end
    end
    if (!did_rst) reset_now();
    s_valid = 1'b0;
    flush   = 1'b0;
    stuck   = 1'b0;
    update_busy();
    drain_wait(2000);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
